conv_engine: RTL and testbench

CONV_ENGINE -- requirements
Module: conv_engine

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_mac.sv | 42 ++++
 rtl/conv_engine.sv | 143 ++++++++++++++
 tb/tb_conv_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, defaults and FSM encoding for the convolution engine.
// The X (kernel) length is a parameter of conv_engine; its default lives here.
package conv_pkg;

  localparam int SIZE_X_DEFAULT = 10;
  localparam int DATA_W         = 16;
  localparam int PROD_W         = 32;
  localparam int X_ADDR_W       = 4;
  localparam int Y_ADDR_W       = 5;
  localparam int Z_ADDR_W       = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ADDR  = 3'd2,
    ST_MAC   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } conv_state_t;

endpackage

// File: rtl/conv_mac.sv
// 16x16 unsigned multiply-accumulate with synchronous clear.
// The accumulator wraps modulo 2^DATAWIDTH.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [DATA_W-1:0]    a,
  input  logic [DATA_W-1:0]    b,
  output logic [DATAWIDTH-1:0] acc
);

  logic [PROD_W-1:0]    prod;
  logic [DATAWIDTH-1:0] acc_reg;
  logic [DATAWIDTH-1:0] acc_next;

  assign prod = PROD_W'(a) * PROD_W'(b);

  always_comb begin
    acc_next = acc_reg;
    if (clear) begin
      acc_next = '0;
    end else if (en) begin
      acc_next = acc_reg + DATAWIDTH'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/conv_engine.sv
// Sequential 1-D convolution: z[n] = sum_k x[k]*y[n-k], one MAC per two cycles.
// X/Y are read from external synchronous memories; each z[n] is written once.
module conv_engine
  import conv_pkg::*;
#(
  parameter int SIZE_X    = SIZE_X_DEFAULT,
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 start,
  input  logic [Y_ADDR_W-1:0]  size_y,
  output logic [X_ADDR_W-1:0]  x_addr,
  input  logic [DATA_W-1:0]    x_data,
  output logic [Y_ADDR_W-1:0]  y_addr,
  input  logic [DATA_W-1:0]    y_data,
  output logic [Z_ADDR_W-1:0]  z_addr,
  output logic [DATAWIDTH-1:0] z_data,
  output logic                 z_we,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [Z_ADDR_W-1:0] X_LAST = Z_ADDR_W'(SIZE_X - 1);

  conv_state_t           state_reg, state_next;
  logic [Y_ADDR_W-1:0]   ny_reg, ny_next;
  logic [Z_ADDR_W-1:0]   n_reg, n_next;
  logic [X_ADDR_W-1:0]   k_reg, k_next;
  logic                  err_reg, err_next;

  logic [Z_ADDR_W-1:0]   ny_ext;
  logic [Z_ADDR_W-1:0]   k_lo;
  logic [Z_ADDR_W-1:0]   k_hi;
  logic [Z_ADDR_W-1:0]   n_last;
  logic                  mac_clear;
  logic                  mac_en;
  logic [DATAWIDTH-1:0]  acc;

  // Summation bounds for the current output index n.
  assign ny_ext = Z_ADDR_W'(ny_reg);
  assign k_lo   = (n_reg >= ny_ext) ? (n_reg - ny_ext + Z_ADDR_W'(1)) : '0;
  assign k_hi   = (n_reg > X_LAST) ? X_LAST : n_reg;
  assign n_last = X_LAST + ny_ext - Z_ADDR_W'(1);

  always_comb begin
    state_next = state_reg;
    ny_next    = ny_reg;
    n_next     = n_reg;
    k_next     = k_reg;
    err_next   = err_reg;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (size_y != '0) begin
            ny_next    = size_y;
            n_next     = '0;
            err_next   = 1'b0;
            state_next = ST_SETUP;
          end else begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        mac_clear  = 1'b1;
        k_next     = X_ADDR_W'(k_lo);
        state_next = ST_ADDR;
      end
      ST_ADDR: begin
        state_next = ST_MAC;
      end
      ST_MAC: begin
        // x_data/y_data now reflect the addresses driven during ADDR.
        mac_en = 1'b1;
        if (Z_ADDR_W'(k_reg) < k_hi) begin
          k_next     = k_reg + X_ADDR_W'(1);
          state_next = ST_ADDR;
        end else begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (n_reg < n_last) begin
          n_next     = n_reg + Z_ADDR_W'(1);
          state_next = ST_SETUP;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_reg <= ST_IDLE;
      ny_reg    <= '0;
      n_reg     <= '0;
      k_reg     <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ny_reg    <= ny_next;
      n_reg     <= n_next;
      k_reg     <= k_next;
      err_reg   <= err_next;
    end
  end

  conv_mac #(
    .DATAWIDTH(DATAWIDTH)
  ) u_mac (
    .clk  (clk),
    .srst (rst_a),
    .clear(mac_clear),
    .en   (mac_en),
    .a    (x_data),
    .b    (y_data),
    .acc  (acc)
  );

  // k never exceeds n and never falls more than NY below it, so n-k fits in y_addr.
  assign x_addr = k_reg;
  assign y_addr = Y_ADDR_W'(n_reg - Z_ADDR_W'(k_reg));
  assign z_we   = (state_reg == ST_WRITE);
  assign z_addr = z_we ? n_reg : '0;
  assign z_data = z_we ? acc : '0;
  assign busy   = (state_reg == ST_SETUP) || (state_reg == ST_ADDR) ||
                  (state_reg == ST_MAC)   || (state_reg == ST_WRITE);
  assign done   = (state_reg == ST_DONE);
  assign err    = err_reg;

endmodule

// File: tb/tb_conv_engine.sv
// Randomised self-checking bench for conv_engine against a direct-sum model.
module tb_conv_engine;

  localparam int SX    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        start;
  logic [4:0]  size_y;
  logic [3:0]  x_addr;
  logic [15:0] x_data;
  logic [4:0]  y_addr;
  logic [15:0] y_data;
  logic [5:0]  z_addr;
  logic [31:0] z_data;
  logic        z_we;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  conv_engine #(.SIZE_X(SX), .DATAWIDTH(DW)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .start (start),
    .size_y(size_y),
    .x_addr(x_addr),
    .x_data(x_data),
    .y_addr(y_addr),
    .y_data(y_data),
    .z_addr(z_addr),
    .z_data(z_data),
    .z_we  (z_we),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  logic [15:0] x_mem [0:15];
  logic [15:0] y_mem [0:31];
  logic [31:0] dut_z [0:63];

  always @(posedge clk) begin
    x_data <= x_mem[x_addr];
    y_data <= y_mem[y_addr];
  end

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t cur;
  int  total_writes = 0;
  int  checks = 0;
  int  passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Direct sum over every k in the kernel, keeping only valid y indices.
  task automatic build_model(input int ny);
    logic [31:0] acc;
    wr_t         w;
    exp_q.delete();
    if (ny > 0) begin
      for (int n = 0; n <= SX + ny - 2; n++) begin
        acc = 32'd0;
        for (int k = 0; k < SX; k++) begin
          if (n - k >= 0 && n - k < ny) acc += 32'(x_mem[k]) * 32'(y_mem[n - k]);
        end
        w.addr = n;
        w.data = acc;
        exp_q.push_back(w);
      end
    end
  endtask

  always @(negedge clk) begin
    if (z_we) begin
      if (exp_q.size() == 0) begin
        chk("spurious_z_we", z_we, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("z_addr", z_addr, cur.addr);
        chk("z_data", z_data, cur.data);
      end
      dut_z[z_addr] = z_data;
      total_writes++;
    end
  end

  task automatic run(input int ny, input bit poke, input bit exp_err);
    int c;
    bit seen;
    int n_exp;
    int w0;
    int exp_lat;
    build_model(ny);
    n_exp   = exp_q.size();
    w0      = total_writes;
    exp_lat = (ny == 0) ? 1 : 2 * (SX + ny - 1) + 2 * SX * ny + 1;
    @(negedge clk);
    start  = 1'b1;
    size_y = 5'(ny);
    @(posedge clk);
    #1;
    start  = 1'b0;
    size_y = 5'($urandom_range(0, 31));
    c    = 0;
    seen = 1'b0;
    while (!seen && c < LIMIT) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        chk("busy_during_run", busy, 1);
        c++;
        start  = poke && (c % 7 == 3);
        size_y = 5'($urandom_range(0, 31));
      end
    end
    chk("done_latency", c + 1, exp_lat);
    chk("err_at_done", err, exp_err);
    chk("busy_in_done", busy, 0);
    chk("write_count", total_writes - w0, n_exp);
    start = poke;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    $display("run ny=%0d poke=%0b latency=%0d writes=%0d err=%0b",
             ny, poke, c + 1, total_writes - w0, err);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) x_mem[i] = 16'($urandom);
    for (int i = 0; i < 32; i++) y_mem[i] = 16'($urandom);
  endtask

  initial begin
    rst_a  = 1'b1;
    start  = 1'b0;
    size_y = 5'd0;
    for (int i = 0; i < 16; i++) x_mem[i] = 16'd0;
    for (int i = 0; i < 32; i++) y_mem[i] = 16'd0;
    for (int i = 0; i < 64; i++) dut_z[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_z_we", z_we, 0);
    chk("rst_z_addr", z_addr, 0);
    chk("rst_z_data", z_data, 0);
    chk("rst_x_addr", x_addr, 0);
    chk("rst_y_addr", y_addr, 0);

    // x = 1..10, y = 1..5
    for (int i = 0; i < SX; i++) x_mem[i] = 16'(i + 1);
    for (int i = 0; i < 5; i++) y_mem[i] = 16'(i + 1);
    run(5, 1'b0, 1'b0);
    chk("lit_z0", dut_z[0], 1);
    chk("lit_z4", dut_z[4], 35);
    chk("lit_z13", dut_z[13], 50);

    // single-tap y scales x
    y_mem[0] = 16'd3;
    run(1, 1'b0, 1'b0);
    for (int n = 0; n < SX; n++) chk("lit_scale", dut_z[n], 3 * (n + 1));

    // empty y flags an error and writes nothing
    run(0, 1'b1, 1'b1);

    // wrap-around with all-ones operands
    for (int i = 0; i < 16; i++) x_mem[i] = 16'hFFFF;
    for (int i = 0; i < 32; i++) y_mem[i] = 16'hFFFF;
    run(2, 1'b0, 1'b0);
    chk("lit_wrap_z0", dut_z[0], 32'hFFFE0001);
    chk("lit_wrap_z1", dut_z[1], 32'hFFFC0002);

    // start pokes while busy and during DONE must be ignored
    fill_random();
    run(4, 1'b1, 1'b0);

    // reset in the middle of a run
    fill_random();
    build_model(5);
    @(negedge clk);
    start  = 1'b1;
    size_y = 5'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_z_we", z_we, 0);
    chk("midrst_done", done, 0);
    chk("midrst_z_data", z_data, 0);
    chk("midrst_x_addr", x_addr, 0);
    $display("reset applied mid-run, busy=%0b z_we=%0b", busy, z_we);
    repeat (10) @(negedge clk);
    run(5, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run($urandom_range(1, 12), r[0], 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
